// File: rtl/control_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// control_sequencer_pkg: opcodes, state encoding and control word.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package control_sequencer_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BRX  = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFLO = 5'b11000;
   localparam logic [4:0] OP_MFHI = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      S_RESET = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
      T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, S_HALT = 4'd9
   } state_t;

   typedef struct packed {
      logic [4:0] opcode;
      logic PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out;
      logic Gra, Grb, Grc, R_in, R_out, BA_out, R15_in;
      logic MAR_enable, MDR_enable, PC_enable, IR_enable, Y_enable, Z_enable;
      logic HI_enable, LO_enable, con_enable, out_port_enable;
      logic IncPC, Read, RAM_write_enable;
   } ctrl_t;

   // Final execute step of each instruction; unlisted opcodes idle one cycle in T3.
   function automatic state_t last_step(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
         OP_ADDI, OP_ANDI, OP_ORI, OP_LDI:  return T5;
         OP_NEG, OP_NOT, OP_JAL:            return T4;
         OP_MUL, OP_DIV, OP_BRX:            return T6;
         OP_LD, OP_ST:                      return T7;
         OP_NOP, OP_HALT:                   return T3;
         default:                           return T3;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_wait_timer.sv
// ----------------------------------------------------------------------------
// ctrl_wait_timer: reloadable down-counter that stretches memory-access states.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ctrl_wait_timer #(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic clk,
   input  logic clr,
   input  logic load,
   output logic done
);

   localparam int unsigned CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
   localparam logic [CW-1:0] C_LOAD = CW'(MEM_WAIT);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = C_LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         cnt_q <= C_LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
// ----------------------------------------------------------------------------
// control_sequencer: hardwired Moore fetch/execute control unit for the Datapath.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module control_sequencer
   import control_sequencer_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic        clk,
   input  logic        clr,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        Stop,
   output logic        Run,
   output logic        PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out,
   output logic        Gra, Grb, Grc, R_in, R_out, BA_out, R15_in,
   output logic        MAR_enable, MDR_enable, PC_enable, IR_enable, Y_enable, Z_enable,
   output logic        HI_enable, LO_enable, con_enable, out_port_enable,
   output logic        IncPC, Read, RAM_write_enable,
   output logic [4:0]  opcode
);

   state_t     state_q, state_d;
   ctrl_t      c;
   logic [4:0] op;
   logic       mem_state, wait_done;
   logic       unused_ir;

   assign op        = IR[31:27];
   assign unused_ir = ^IR[26:0];

   always_comb begin
      c = '0;
      case (state_q)
         T0: begin c.PC_out = 1'b1; c.MAR_enable = 1'b1; c.IncPC = 1'b1; c.PC_enable = 1'b1; end
         T1: begin c.Read = 1'b1; c.MDR_enable = 1'b1; end
         T2: begin c.MDR_out = 1'b1; c.IR_enable = 1'b1; end
         T3: case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI: begin c.Grb = 1'b1; c.R_out = 1'b1; c.Y_enable = 1'b1; end
            OP_NEG, OP_NOT: begin c.Grb = 1'b1; c.R_out = 1'b1; c.opcode = op; c.Z_enable = 1'b1; end
            OP_MUL, OP_DIV: begin c.Gra = 1'b1; c.R_out = 1'b1; c.Y_enable = 1'b1; end
            OP_LD, OP_LDI, OP_ST: begin c.Grb = 1'b1; c.BA_out = 1'b1; c.Y_enable = 1'b1; end
            OP_BRX: begin c.Gra = 1'b1; c.R_out = 1'b1; c.con_enable = 1'b1; end
            OP_JR:  begin c.Gra = 1'b1; c.R_out = 1'b1; c.PC_enable = 1'b1; end
            OP_JAL: begin c.PC_out = 1'b1; c.R15_in = 1'b1; end
            OP_IN:  begin c.In_port_out = 1'b1; c.Gra = 1'b1; c.R_in = 1'b1; end
            OP_OUT: begin c.Gra = 1'b1; c.R_out = 1'b1; c.out_port_enable = 1'b1; end
            OP_MFHI: begin c.HI_out = 1'b1; c.Gra = 1'b1; c.R_in = 1'b1; end
            OP_MFLO: begin c.LO_out = 1'b1; c.Gra = 1'b1; c.R_in = 1'b1; end
            default: ;
         endcase
         T4: case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL:
               begin c.Grc = 1'b1; c.R_out = 1'b1; c.opcode = op; c.Z_enable = 1'b1; end
            OP_ADDI, OP_ANDI, OP_ORI: begin
               c.C_out    = 1'b1;
               c.opcode   = (op == OP_ADDI) ? OP_ADD : (op == OP_ANDI) ? OP_AND : OP_OR;
               c.Z_enable = 1'b1;
            end
            OP_NEG, OP_NOT: begin c.ZLow_out = 1'b1; c.Gra = 1'b1; c.R_in = 1'b1; end
            OP_MUL, OP_DIV: begin c.Grb = 1'b1; c.R_out = 1'b1; c.opcode = op; c.Z_enable = 1'b1; end
            OP_LD, OP_LDI, OP_ST: begin c.C_out = 1'b1; c.opcode = OP_ADD; c.Z_enable = 1'b1; end
            OP_BRX: begin c.PC_out = 1'b1; c.Y_enable = 1'b1; end
            OP_JAL: begin c.Gra = 1'b1; c.R_out = 1'b1; c.PC_enable = 1'b1; end
            default: ;
         endcase
         T5: case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
            OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin c.ZLow_out = 1'b1; c.Gra = 1'b1; c.R_in = 1'b1; end
            OP_MUL, OP_DIV: begin c.ZLow_out = 1'b1; c.LO_enable = 1'b1; end
            OP_LD, OP_ST:   begin c.ZLow_out = 1'b1; c.MAR_enable = 1'b1; end
            OP_BRX: begin c.C_out = 1'b1; c.opcode = OP_ADD; c.Z_enable = 1'b1; end
            default: ;
         endcase
         T6: case (op)
            OP_MUL, OP_DIV: begin c.ZHigh_out = 1'b1; c.HI_enable = 1'b1; end
            OP_LD:  begin c.Read = 1'b1; c.MDR_enable = 1'b1; end
            OP_ST:  begin c.Gra = 1'b1; c.R_out = 1'b1; c.MDR_enable = 1'b1; end
            OP_BRX: if (CON_FF) begin c.ZLow_out = 1'b1; c.PC_enable = 1'b1; end
            default: ;
         endcase
         T7: case (op)
            OP_LD: begin c.MDR_out = 1'b1; c.Gra = 1'b1; c.R_in = 1'b1; end
            OP_ST: c.RAM_write_enable = 1'b1;
            default: ;
         endcase
         default: ;
      endcase
   end

   // Memory-access states are recognised from their own decoded strobes.
   assign mem_state = c.Read | c.RAM_write_enable;

   ctrl_wait_timer #(.MEM_WAIT(MEM_WAIT)) u_wait_timer (
      .clk  (clk),
      .clr  (clr),
      .load (!mem_state || wait_done),
      .done (wait_done)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RESET: state_d = T0;
         S_HALT:  state_d = S_HALT;
         default: if (!mem_state || wait_done) begin
            if (state_q == last_step(op)) begin
               state_d = (Stop || op == OP_HALT) ? S_HALT : T0;
            end else begin
               state_d = state_t'(state_q + 4'd1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q <= S_RESET;
      end else begin
         state_q <= state_d;
      end
   end

   assign Run              = (state_q != S_RESET) && (state_q != S_HALT);
   assign opcode           = c.opcode;
   assign PC_out           = c.PC_out;
   assign MDR_out          = c.MDR_out;
   assign ZLow_out         = c.ZLow_out;
   assign ZHigh_out        = c.ZHigh_out;
   assign HI_out           = c.HI_out;
   assign LO_out           = c.LO_out;
   assign C_out            = c.C_out;
   assign In_port_out      = c.In_port_out;
   assign Gra              = c.Gra;
   assign Grb              = c.Grb;
   assign Grc              = c.Grc;
   assign R_in             = c.R_in;
   assign R_out            = c.R_out;
   assign BA_out           = c.BA_out;
   assign R15_in           = c.R15_in;
   assign MAR_enable       = c.MAR_enable;
   assign MDR_enable       = c.MDR_enable;
   assign PC_enable        = c.PC_enable;
   assign IR_enable        = c.IR_enable;
   assign Y_enable         = c.Y_enable;
   assign Z_enable         = c.Z_enable;
   assign HI_enable        = c.HI_enable;
   assign LO_enable        = c.LO_enable;
   assign con_enable       = c.con_enable;
   assign out_port_enable  = c.out_port_enable;
   assign IncPC            = c.IncPC;
   assign Read             = c.Read;
   assign RAM_write_enable = c.RAM_write_enable;

   a_one_bus_driver: assert property (@(posedge clk) disable iff (!clr)
      $onehot0({PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out, R_out, BA_out}));

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ----------------------------------------------------------------------------
// tb_control_sequencer: vector table, random instruction stream and corner cases.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_control_sequencer;

   localparam int unsigned MEM_WAIT = 2;

   typedef logic [33:0] cw_t;
   localparam cw_t ONE  = 34'd1;
   localparam cw_t RUN  = ONE << 33;
   localparam cw_t PCO  = ONE << 27, MDRO = ONE << 26, ZLO  = ONE << 25, ZHO  = ONE << 24;
   localparam cw_t HIO  = ONE << 23, LOO  = ONE << 22, CO   = ONE << 21, INO  = ONE << 20;
   localparam cw_t GRA  = ONE << 19, GRB  = ONE << 18, GRC  = ONE << 17, RIN  = ONE << 16;
   localparam cw_t ROUT = ONE << 15, BAO  = ONE << 14, R15  = ONE << 13, MARE = ONE << 12;
   localparam cw_t MDRE = ONE << 11, PCE  = ONE << 10, IRE  = ONE << 9,  YE   = ONE << 8;
   localparam cw_t ZE   = ONE << 7,  HIE  = ONE << 6,  LOE  = ONE << 5,  CONE = ONE << 4;
   localparam cw_t OUTE = ONE << 3,  INC  = ONE << 2,  RD   = ONE << 1,  WR   = ONE << 0;
   localparam cw_t T0W  = RUN | PCO | MARE | INC | PCE;

   logic clk = 1'b0;
   logic clr, CON_FF, Stop;
   logic [31:0] IR;
   logic Run, PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out;
   logic Gra, Grb, Grc, R_in, R_out, BA_out, R15_in;
   logic MAR_enable, MDR_enable, PC_enable, IR_enable, Y_enable, Z_enable;
   logic HI_enable, LO_enable, con_enable, out_port_enable, IncPC, Read, RAM_write_enable;
   logic [4:0] opcode;
   cw_t act;

   int checks = 0;
   int failures = 0;
   cw_t exp_q[$];

   assign act = {Run, opcode, PC_out, MDR_out, ZLow_out, ZHigh_out, HI_out, LO_out, C_out, In_port_out,
                 Gra, Grb, Grc, R_in, R_out, BA_out, R15_in, MAR_enable, MDR_enable, PC_enable,
                 IR_enable, Y_enable, Z_enable, HI_enable, LO_enable, con_enable, out_port_enable,
                 IncPC, Read, RAM_write_enable};

   control_sequencer #(.MEM_WAIT(MEM_WAIT)) dut (
      .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
      .PC_out(PC_out), .MDR_out(MDR_out), .ZLow_out(ZLow_out), .ZHigh_out(ZHigh_out),
      .HI_out(HI_out), .LO_out(LO_out), .C_out(C_out), .In_port_out(In_port_out),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .R_in(R_in), .R_out(R_out), .BA_out(BA_out), .R15_in(R15_in),
      .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .PC_enable(PC_enable), .IR_enable(IR_enable),
      .Y_enable(Y_enable), .Z_enable(Z_enable), .HI_enable(HI_enable), .LO_enable(LO_enable),
      .con_enable(con_enable), .out_port_enable(out_port_enable), .IncPC(IncPC), .Read(Read),
      .RAM_write_enable(RAM_write_enable), .opcode(opcode)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input cw_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic cw_t opw(input logic [4:0] o);
      return cw_t'(o) << 28;
   endfunction

   // A step that touches memory occupies MEM_WAIT+1 cycles.
   task automatic add_step(input cw_t w);
      int n;
      n = ((w & (RD | WR)) != '0) ? int'(MEM_WAIT) + 1 : 1;
      for (int k = 0; k < n; k++) exp_q.push_back(w | RUN);
   endtask

   // Expected per-cycle control words for one instruction, from fetch to its last step.
   task automatic build(input logic [4:0] op, input logic con);
      exp_q.delete();
      add_step(PCO | MARE | INC | PCE);
      add_step(RD | MDRE);
      add_step(MDRO | IRE);
      if (op >= 5'd3 && op <= 5'd11) begin
         add_step(GRB | ROUT | YE);
         add_step(GRC | ROUT | opw(op) | ZE);
         add_step(ZLO | GRA | RIN);
      end else if (op >= 5'd12 && op <= 5'd14) begin
         add_step(GRB | ROUT | YE);
         add_step(CO | ZE | opw((op == 5'd12) ? 5'd3 : (op == 5'd13) ? 5'd5 : 5'd6));
         add_step(ZLO | GRA | RIN);
      end else begin
         case (op)
            5'd17, 5'd18: begin add_step(GRB | ROUT | opw(op) | ZE); add_step(ZLO | GRA | RIN); end
            5'd15, 5'd16: begin
               add_step(GRA | ROUT | YE);  add_step(GRB | ROUT | opw(op) | ZE);
               add_step(ZLO | LOE);        add_step(ZHO | HIE);
            end
            5'd0, 5'd1, 5'd2: begin
               add_step(GRB | BAO | YE);
               add_step(CO | opw(5'd3) | ZE);
               if (op == 5'd1) add_step(ZLO | GRA | RIN);
               else if (op == 5'd0) begin
                  add_step(ZLO | MARE); add_step(RD | MDRE); add_step(MDRO | GRA | RIN);
               end else begin
                  add_step(ZLO | MARE); add_step(GRA | ROUT | MDRE); add_step(WR);
               end
            end
            5'd19: begin
               add_step(GRA | ROUT | CONE); add_step(PCO | YE);
               add_step(CO | opw(5'd3) | ZE); add_step(con ? (ZLO | PCE) : '0);
            end
            5'd20: add_step(GRA | ROUT | PCE);
            5'd21: begin add_step(PCO | R15); add_step(GRA | ROUT | PCE); end
            5'd22: add_step(INO | GRA | RIN);
            5'd23: add_step(GRA | ROUT | OUTE);
            5'd24: add_step(LOO | GRA | RIN);
            5'd25: add_step(HIO | GRA | RIN);
            default: add_step('0);
         endcase
      end
   endtask

   // Starts with the DUT in T0; returns the cycles observed until it is back in T0.
   task automatic run_instr(input string name, input logic [31:0] ir, input logic con,
                            input logic stp, output int len);
      logic halts;
      IR = ir; CON_FF = con; Stop = stp;
      build(ir[31:27], con);
      halts = stp || (ir[31:27] == 5'd27);
      len = 0;
      if (halts) begin
         foreach (exp_q[i]) begin
            chk(name, exp_q[i]);
            step();
            len++;
         end
      end else begin
         do begin
            chk(name, (len < exp_q.size()) ? exp_q[len] : T0W);
            step();
            len++;
         end while (!IncPC && len < 40);
      end
   endtask

   task automatic do_reset();
      #2 clr = 1'b0;
      #1 chk("async_reset", '0);
      step();
      chk("reset_hold", '0);
      clr = 1'b1;
      step();
      chk("t0_after_reset", T0W);
   endtask

   typedef struct {
      logic [31:0] ir;
      logic        con;
      int          cycles;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int len;
      logic [4:0] rop;

      tbl[0]  = '{32'h1A2B8000, 1'b0, 8};   // add
      tbl[1]  = '{32'h00800055, 1'b0, 12};  // ld
      tbl[2]  = '{32'h08800000, 1'b0, 8};   // ldi
      tbl[3]  = '{32'h10000000, 1'b0, 12};  // st
      tbl[4]  = '{32'h98000000, 1'b0, 9};   // brx not taken
      tbl[5]  = '{32'h98000000, 1'b1, 9};   // brx taken
      tbl[6]  = '{32'h80000000, 1'b0, 9};   // mul
      tbl[7]  = '{32'h88000000, 1'b0, 7};   // neg
      tbl[8]  = '{32'hA8000000, 1'b0, 7};   // jal
      tbl[9]  = '{32'hC8000000, 1'b0, 6};   // mfhi
      tbl[10] = '{32'h60000000, 1'b0, 8};   // addi
      tbl[11] = '{32'hF8000000, 1'b0, 6};   // undefined opcode

      clr = 1'b0; IR = '0; CON_FF = 1'b0; Stop = 1'b0;
      repeat (3) begin
         step();
         chk("reset", '0);
      end
      clr = 1'b1;
      step();
      chk("t0_after_reset", T0W);

      foreach (tbl[i]) begin
         run_instr("vec", tbl[i].ir, tbl[i].con, 1'b0, len);
         checks++;
         if (len != tbl[i].cycles) begin
            failures++;
            $display("FAIL vec_len[%0d]: got %0d cycles expected %0d", i, len, tbl[i].cycles);
         end
      end

      for (int n = 0; n < 150; n++) begin
         rop = 5'($urandom_range(31));
         if (rop == 5'd27) rop = 5'd26;
         run_instr("rand", {rop, 27'($urandom)}, 1'($urandom_range(1)), 1'b0, len);
         checks++;
         if (len != exp_q.size()) begin
            failures++;
            $display("FAIL rand_len: op %b got %0d cycles expected %0d", rop, len, exp_q.size());
         end
      end

      // Stop during mul completes the instruction, then halts for good.
      run_instr("mul_stop", 32'h80000000, 1'b0, 1'b1, len);
      Stop = 1'b0;
      repeat (20) begin
         chk("halted_after_stop", '0);
         step();
      end
      do_reset();

      run_instr("halt_op", 32'hD8000000, 1'b0, 1'b0, len);
      repeat (5) begin
         chk("halted_after_halt", '0);
         step();
      end
      do_reset();

      // Reset asserted during the store write cycle kills the write at once.
      IR = 32'h10000000; CON_FF = 1'b0; Stop = 1'b0;
      build(5'd2, 1'b0);
      for (int i = 0; i < exp_q.size(); i++) begin
         chk("st_pre", exp_q[i]);
         if ((exp_q[i] & WR) != '0) break;
         step();
      end
      #3 clr = 1'b0;
      #1 chk("st_clr_write_off", '0);
      step();
      chk("st_clr_hold", '0);
      clr = 1'b1;
      step();
      chk("st_restart_t0", T0W);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
